btn_debouncer: RTL and testbench

Conditions the raw push-button inputs of the traffic-light board before they reach the controller's `btn_i` port. Each button passes through a two-flop synchronizer and a per-button debounce state machine. The block produces a clean level and a single-cycle press pulse per button, so the controller sees exactly one event per physical press. It runs on the system clock, not the divided time clock.

---
 rtl/btn_debouncer_if.sv | 21 ++
 rtl/btn_debouncer.sv | 160 ++++++++++++++++
 tb/tb_btn_debouncer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/btn_debouncer_if.sv
// Button bus between the board pads (master side) and the debouncer (slave side).
// Carries the raw pad levels in and the debounced level/pulse vectors out.
interface btn_debouncer_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw_i;
    logic [N_BTN-1:0] btn_level_o;
    logic [N_BTN-1:0] btn_pulse_o;

    modport master (
        output btn_raw_i,
        input  btn_level_o,
        input  btn_pulse_o
    );

    modport slave (
        input  btn_raw_i,
        output btn_level_o,
        output btn_pulse_o
    );
endinterface

// File: rtl/btn_debouncer.sv
// Push-button conditioner: two-flop synchronizer plus a per-button debounce FSM giving a
// clean level and a one-cycle press pulse. Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses.
module btn_debouncer #(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 1_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    btn_debouncer_if.slave bus
);

    localparam int              CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int              REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int              REP_W      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`endif

    if (DB_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("btn_debouncer: DB_CYCLES must be >= 2 and REPEAT_* must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } state_t;

    logic [N_BTN-1:0] s1;
    logic [N_BTN-1:0] s2;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.btn_raw_i;
            s2 <= s1;
        end
    end

    wire [N_BTN-1:0] level_vec;
    wire [N_BTN-1:0] pulse_vec;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;
`ifdef BTN_AUTOREPEAT_EN
        // rep_q marks that the first (long) repeat interval has already elapsed.
        logic [REP_W-1:0] rcnt_q, rcnt_d;
        logic             rep_q, rep_d;
`endif

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                rcnt_q  <= '0;
                rep_q   <= 1'b0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
`ifdef BTN_AUTOREPEAT_EN
                rcnt_q  <= rcnt_d;
                rep_q   <= rep_d;
`endif
            end
        end

        // NOTE: every combinational output is defaulted first so no path can infer a latch.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            pulse_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rcnt_d  = rcnt_q;
            rep_d   = rep_q;
`endif
            unique case (state_q)
                IDLE: begin
                    if (s2[i]) begin
                        state_d = PRESS_CHK;
                        cnt_d   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (!s2[i]) begin
                        state_d = IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HELD;
                        level_d = 1'b1;
                        pulse_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt_d  = '0;
                        rep_d   = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!s2[i]) begin
                        state_d = REL_CHK;
                        cnt_d   = '0;
                    end
`ifdef BTN_AUTOREPEAT_EN
                    else if (rcnt_q == (rep_q ? PERIOD_LAST : DELAY_LAST)) begin
                        pulse_d = 1'b1;
                        rcnt_d  = '0;
                        rep_d   = 1'b1;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
`endif
                end
                REL_CHK: begin
                    // The repeat counter is left untouched here, so a bounce back to HELD resumes it.
                    if (s2[i]) begin
                        state_d = HELD;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                        level_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
                        rcnt_d  = '0;
                        rep_d   = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        assign level_vec[i] = level_q;
        assign pulse_vec[i] = pulse_q;
    end

    assign bus.btn_level_o = level_vec;
    assign bus.btn_pulse_o = pulse_vec;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DB_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=5.
// Expected pulse edges follow BTN_AUTOREPEAT_EN when the bench is built with it defined.
module tb_btn_debouncer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    btn_debouncer_if #(.N_BTN(4)) bus ();

    btn_debouncer #(
        .N_BTN        (4),
        .DB_CYCLES    (4),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(5)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Press first sampled at edge 0 -> pulse after edge 6; with auto-repeat, 14 then every 5,
    // while the button is still HELD (raw low first sampled at edge `hold` leaves HELD at hold+2).
    function automatic bit pulse_event(input int e, input int hold);
        bit held;
        held = (e <= hold + 1);
        if (e == 6 && held) return 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        if (held && e >= 14 && ((e - 14) % 5) == 0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Called at a negedge; the next posedge is edge 0. Raw low is first sampled at edge `hold`.
    task automatic press_seq(input logic [3:0] mask, input int hold, input string name);
        logic [3:0] exp_level;
        logic [3:0] exp_pulse;
        bus.btn_raw_i = mask;
        for (int e = 0; e <= hold + 8; e++) begin
            @(negedge clk);
            exp_level = (e >= 6 && e < hold + 6) ? mask : 4'b0000;
            exp_pulse = pulse_event(e, hold) ? mask : 4'b0000;
            check($sformatf("%s level e%0d", name, e), bus.btn_level_o, exp_level);
            check($sformatf("%s pulse e%0d", name, e), bus.btn_pulse_o, exp_pulse);
            if (e == hold - 1) bus.btn_raw_i = 4'b0000;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.btn_raw_i = 4'b0000;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset level", bus.btn_level_o, 4'b0000);
        check("reset pulse", bus.btn_pulse_o, 4'b0000);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle level", bus.btn_level_o, 4'b0000);
        check("idle pulse", bus.btn_pulse_o, 4'b0000);

        // Clean press on bit 0, held 20 cycles, then release.
        press_seq(4'b0001, 20, "clean");

        // Bounce on bit 1: 1,0,1,0 then 0 -- never accepted.
        bus.btn_raw_i = 4'b0010;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            check($sformatf("bounce level e%0d", e), bus.btn_level_o, 4'b0000);
            check($sformatf("bounce pulse e%0d", e), bus.btn_pulse_o, 4'b0000);
            bus.btn_raw_i = (e + 1 == 2) ? 4'b0010 : 4'b0000;
        end

        // Simultaneous press and release of bits 3:2.
        press_seq(4'b1100, 20, "simul");

        // Reset asserted asynchronously just after edge 4 while bit 0 is in PRESS_CHK.
        bus.btn_raw_i = 4'b0001;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst mid level", bus.btn_level_o, 4'b0000);
        check("rst mid pulse", bus.btn_pulse_o, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst hold level %0d", k), bus.btn_level_o, 4'b0000);
            check($sformatf("rst hold pulse %0d", k), bus.btn_pulse_o, 4'b0000);
        end

        // Release reset with the button still held: a fresh press with full latency.
        rst = 1'b0;
        for (int e = 0; e <= 10; e++) begin
            @(negedge clk);
            check($sformatf("post-rst level e%0d", e), bus.btn_level_o, (e >= 6) ? 4'b0001 : 4'b0000);
            check($sformatf("post-rst pulse e%0d", e), bus.btn_pulse_o, (e == 6) ? 4'b0001 : 4'b0000);
        end

        // Reset while HELD must clear the level asynchronously.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst held level", bus.btn_level_o, 4'b0000);
        check("rst held pulse", bus.btn_pulse_o, 4'b0000);
        bus.btn_raw_i = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post-rst idle level", bus.btn_level_o, 4'b0000);

        // 30-cycle hold on bit 0 (single pulse, or repeats when auto-repeat is built in).
        press_seq(4'b0001, 30, "hold30");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
